// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its round-robin picker.
// The optional stall timeout is enabled by defining ARB_TIMEOUT_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_e;

    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 5_000_000;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from ptr+1.
// Reusable by any arbiter that keeps its own last-winner pointer.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        // i runs 1..NUM_REQ so the previous winner is considered last
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between byte producers.
// Define ARB_TIMEOUT_EN to force release of an owner that stalls mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic             last_q;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    assign arb_busy = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`else
    // Evaluates to constant 0 in this build
    assign timeout_err = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_REQ - 1);
            gidx     <= '0;
            grant    <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            last_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gidx  <= pick;
                        grant <= NUM_REQ'(1) << pick;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req[gidx]) begin
                        if (!tx_busy) begin
                            tx_data  <= req_data[{gidx, 3'b000} +: 8];
                            tx_start <= 1'b1;
                            ack      <= NUM_REQ'(1) << gidx;
                            last_q   <= req_last[gidx];
                            state    <= WAIT_START;
`ifdef ARB_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // Owner stalled mid-packet: release it after TIMEOUT_CYC idle cycles
                    else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= gidx;
                        grant       <= '0;
                        to_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            ptr   <= gidx;
                            grant <= '0;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
